// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the register-list sequencer.
// S_WB is only part of the encoding when REG_LIST_SEQ_WB_EN is defined.
package cpu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDREG = 3'd1,
        S_XFER  = 3'd2,
`ifdef REG_LIST_SEQ_WB_EN
        S_WB    = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-entry register mask.
module lsb_prio_enc
    import cpu_pkg::*;
(
    input  logic [NUM_REGS-1:0] i_mask,
    output logic [3:0]          o_idx,
    output logic                o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_list_seq.sv
// Load/store-multiple sequencer: one memory word per register in the mask.
// Base-register writeback (WB state) is built only with REG_LIST_SEQ_WB_EN.
module reg_list_seq
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_load,
    input  logic [15:0] i_reg_list,
    input  logic [31:0] i_base,
    input  logic [3:0]  i_addr_rn,
    input  logic        i_up,
    input  logic        i_before,
    input  logic        i_wb,
    output logic [3:0]  o_addr_rt,
    input  logic [31:0] i_rt,
    output logic [3:0]  o_addr_rd,
    output logic [31:0] o_rd,
    output logic        o_rd_wr_en,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_done
);

    state_e      state_q, state_d;
    logic [15:0] mask_q;
    logic [31:0] base_q;
    logic        load_q, up_q, before_q;
    logic        cap_q;
    logic [4:0]  cnt_q;
    logic [31:0] wdata_q, rd_q;
    logic [3:0]  addr_rd_q;
    logic        rd_we_q, done_q;

    logic [3:0]  idx;
    logic        idx_vld;
    logic [15:0] rest;
    logic        last, start_ok, mem_req, ack_ok;
    logic [31:0] off, addr;

    logic unused_lo;
    assign unused_lo = ^i_base[1:0];

`ifdef REG_LIST_SEQ_WB_EN
    logic        wb_q, rn_hit_q, wb_go;
    logic [3:0]  rn_q;
    logic [31:0] wb_off, wb_val;
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_wb, i_addr_rn};
`endif

    lsb_prio_enc u_enc (
        .i_mask  (mask_q),
        .o_idx   (idx),
        .o_valid (idx_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        start_ok = (state_q == S_IDLE) && i_start;
        // Stores spend their first XFER cycle capturing i_rt; no request yet.
        mem_req  = (state_q == S_XFER) && !cap_q && idx_vld;
        ack_ok   = mem_req && i_mem_ack;
        rest     = mask_q & ~(16'd1 << idx);
        last     = (rest == '0);
        off      = (32'(cnt_q) + 32'(before_q)) * WORD_BYTES;
        addr     = up_q ? base_q + off : base_q - off;
`ifdef REG_LIST_SEQ_WB_EN
        wb_go    = wb_q && !(load_q && (rn_hit_q || idx == rn_q));
        wb_off   = 32'(cnt_q) * WORD_BYTES;
        wb_val   = up_q ? base_q + wb_off : base_q - wb_off;
`endif

        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_reg_list == '0) state_d = S_DONE;
                    else if (i_load)      state_d = S_XFER;
                    else                  state_d = S_RDREG;
                end
            end
            S_RDREG: state_d = S_XFER;
            S_XFER: begin
                if (ack_ok) begin
                    if (last) begin
`ifdef REG_LIST_SEQ_WB_EN
                        state_d = wb_go ? S_WB : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end else if (!load_q) begin
                        state_d = S_RDREG;
                    end
                end
            end
`ifdef REG_LIST_SEQ_WB_EN
            S_WB:    state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        o_addr_rt   = (state_q == S_RDREG) ? idx : 4'd0;
        o_mem_req   = mem_req;
        o_mem_we    = mem_req && !load_q;
        o_mem_addr  = mem_req ? addr : 32'd0;
        o_mem_wdata = (mem_req && !load_q) ? wdata_q : 32'd0;
        o_addr_rd   = addr_rd_q;
        o_rd        = rd_q;
        o_rd_wr_en  = rd_we_q;
        o_done      = done_q;
        o_busy      = !rst && ((state_q != S_IDLE) || i_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            base_q    <= '0;
            load_q    <= 1'b0;
            up_q      <= 1'b0;
            before_q  <= 1'b0;
            cap_q     <= 1'b0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            addr_rd_q <= '0;
            rd_we_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef REG_LIST_SEQ_WB_EN
            wb_q      <= 1'b0;
            rn_q      <= '0;
            rn_hit_q  <= 1'b0;
`endif
        end else begin
            rd_we_q <= 1'b0;
            done_q  <= (state_q == S_DONE);
            if (start_ok) begin
                mask_q   <= i_reg_list;
                base_q   <= {i_base[31:2], 2'b00};
                load_q   <= i_load;
                up_q     <= i_up;
                before_q <= i_before;
                cnt_q    <= '0;
`ifdef REG_LIST_SEQ_WB_EN
                wb_q     <= i_wb;
                rn_q     <= i_addr_rn;
                rn_hit_q <= 1'b0;
`endif
            end
            if (state_q == S_RDREG) cap_q <= 1'b1;
            if (state_q == S_XFER && cap_q) begin
                wdata_q <= i_rt;
                cap_q   <= 1'b0;
            end
            if (ack_ok) begin
                mask_q <= rest;
                cnt_q  <= cnt_q + 5'd1;
                if (load_q) begin
                    rd_q      <= i_mem_rdata;
                    addr_rd_q <= idx;
                    rd_we_q   <= 1'b1;
`ifdef REG_LIST_SEQ_WB_EN
                    if (idx == rn_q) rn_hit_q <= 1'b1;
`endif
                end
            end
`ifdef REG_LIST_SEQ_WB_EN
            if (state_q == S_WB) begin
                rd_q      <= wb_val;
                addr_rd_q <= rn_q;
                rd_we_q   <= 1'b1;
            end
`endif
        end
    end

endmodule
